// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the instruction fetch unit.
//   fetch_state_t : RUN (normal fetching) / DRAIN (waiting out a stale request)
//   fetch_entry_t : prefetch FIFO entry, instruction word tagged with its PC
//   WORD_BYTES    : PC increment per fetched word
package fetch_pkg;

  typedef enum logic {RUN, DRAIN} fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry prefetch FIFO of fetch_entry_t.
// Ports:
//   clk, reset       : clock, async active-high reset
//   push/wdata       : enqueue (ignored when full)
//   pop              : dequeue head (ignored when empty)
//   flush            : empty the FIFO; wins over push and pop
//   rdata            : head entry (undefined when empty)
//   count/full/empty : occupancy
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetcher feeding a prefetch FIFO.
// Optional build macro: FETCH_STATS_EN adds fetch_count / flush_count outputs.
// Ports:
//   clk, reset                        : clock, async active-high reset
//   imem_req/imem_addr                : request to instruction memory (held until ack)
//   imem_ack/imem_rdata               : memory response
//   instr_valid/instr/instr_pc        : FIFO head to the core (0 when empty)
//   instr_ready                       : core consumes head
//   redirect/redirect_pc              : taken branch, flush and restart at target
//   fetch_count/flush_count           : (FETCH_STATS_EN) push / redirect counters
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
`ifdef FETCH_STATS_EN
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count,
`endif
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  fetch_state_t state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] drain_pc, drain_pc_n;   // address of the stale request being drained
  logic        run_en;                 // holds req low for the first cycle out of reset
  logic        push, pop;
  logic        fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  fetch_entry_t head;
  logic [31:0] target;
  logic [1:0]  unused_rpc_lo;

  assign target        = {redirect_pc[31:2], 2'b00};
  assign unused_rpc_lo = redirect_pc[1:0];

  // In RUN req can only fall via a push filling the FIFO, i.e. after an ack,
  // so the hold-until-ack rule holds without extra state.
  assign imem_req  = run_en && ((state == DRAIN) || !fifo_full);
  assign imem_addr = (state == DRAIN) ? drain_pc : fetch_pc;

  assign push = (state == RUN) && imem_req && imem_ack && !redirect;
  assign pop  = instr_valid && instr_ready;

  assign instr_valid = (fifo_count != '0);
  assign instr       = fifo_empty ? '0 : head.instr;
  assign instr_pc    = fifo_empty ? '0 : head.pc;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ('{instr: imem_rdata, pc: fetch_pc}),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      drain_pc <= RESET_PC;
      run_en   <= 1'b0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      drain_pc <= drain_pc_n;
      run_en   <= 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    drain_pc_n = drain_pc;
    case (state)
      RUN: begin
        if (redirect) begin
          fetch_pc_n = target;
          // Un-acked request must be seen through at its old address.
          if (imem_req && !imem_ack) begin
            state_n    = DRAIN;
            drain_pc_n = fetch_pc;
          end
        end else if (push) begin
          fetch_pc_n = fetch_pc + WORD_BYTES;
        end
      end
      DRAIN: begin
        if (imem_ack) state_n = RUN;
        if (redirect) fetch_pc_n = target;
      end
      default: state_n = RUN;
    endcase
  end

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (push)     fetch_count <= fetch_count + 32'd1;
      if (redirect) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed + randomized bench for fetch_unit against a
// queue-based reference model driven by a variable-latency memory model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req, imem_ack, instr_valid, instr_ready, redirect;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count, flush_count;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
`ifdef FETCH_STATS_EN
    .fetch_count (fetch_count),
    .flush_count (flush_count),
`endif
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: expected FIFO contents as a queue, next fetch address,
  // and whether a stale request is being waited out.
  fetch_entry_t q[$];
  logic [31:0]  m_pc, m_drain_pc, m_fetches, m_flushes;
  bit           m_drain, m_started;

  // Memory model
  int lat  = 0;
  int wcnt = 0;
  int acks_seen = 0;
  bit data_is_addr = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return data_is_addr ? a : ((a ^ 32'h5A5A_C3C3) + 32'h0000_1234);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_req();
    return m_started && (m_drain || q.size() < DEPTH);
  endfunction

  task automatic model_reset();
    q.delete();
    m_pc = RST_PC; m_drain_pc = RST_PC; m_drain = 1'b0; m_started = 1'b0;
    m_fetches = '0; m_flushes = '0;
    wcnt = 0;
  endtask

  task automatic check_outputs();
    chk("imem_req",    {31'd0, imem_req},    {31'd0, m_req()});
    chk("imem_addr",   imem_addr,            m_drain ? m_drain_pc : m_pc);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, q.size() > 0});
    chk("instr",       instr,                q.size() > 0 ? q[0].instr : 32'd0);
    chk("instr_pc",    instr_pc,             q.size() > 0 ? q[0].pc : 32'd0);
`ifdef FETCH_STATS_EN
    chk("fetch_count", fetch_count, m_fetches);
    chk("flush_count", flush_count, m_flushes);
`endif
  endtask

  task automatic model_update(input bit rdy, input bit rd, input logic [31:0] rpc,
                              input bit ack, input logic [31:0] rdata);
    logic [31:0] tgt;
    bit req, eff_ack;
    tgt     = {rpc[31:2], 2'b00};
    req     = m_req();
    eff_ack = req && ack;
    if (rd) m_flushes++;
    if (m_drain) begin
      if (rd) m_pc = tgt;
      if (eff_ack) m_drain = 1'b0;
      q.delete();
    end else if (rd) begin
      if (req && !ack) begin
        m_drain    = 1'b1;
        m_drain_pc = m_pc;
      end
      m_pc = tgt;
      q.delete();
    end else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (eff_ack) begin
        q.push_back('{instr: rdata, pc: m_pc});
        m_pc = m_pc + 32'd4;
        m_fetches++;
      end
    end
    m_started = 1'b1;
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic step(input bit rdy, input bit rd, input logic [31:0] rpc);
    bit req_s, ack_s;
    logic [31:0] rdata_s;
    instr_ready = rdy; redirect = rd; redirect_pc = rpc;
    #1;
    if (imem_req) begin
      imem_ack   = (wcnt >= lat);
      imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom;
    end else begin
      imem_ack   = ($urandom_range(0, 3) == 0);   // stray ack, must be ignored
      imem_rdata = $urandom;
    end
    #1;
    check_outputs();
    req_s = imem_req; ack_s = imem_ack; rdata_s = imem_rdata;
    @(posedge clk);
    model_update(rdy, rd, rpc, ack_s, rdata_s);
    if (req_s && ack_s) begin
      acks_seen++;
      wcnt = 0;
    end else if (req_s) begin
      wcnt++;
    end
    #1;
  endtask

  // Asserts reset at posedge+2, checks its immediate effect, releases at next posedge+1.
  task automatic apply_reset();
    #1;
    reset = 1'b1;
    imem_ack = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_req",   {31'd0, imem_req},    32'd0);
    chk("rst_addr",  imem_addr,            RST_PC);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr,                32'd0);
    chk("rst_pc",    instr_pc,             32'd0);
`ifdef FETCH_STATS_EN
    chk("rst_fetch_count", fetch_count, 32'd0);
    chk("rst_flush_count", flush_count, 32'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    #1;
    apply_reset();

    // Zero-wait memory, data == address: 0,4,8,... with first valid in cycle 2.
    lat = 0; data_is_addr = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i < 2) chk("seq_valid_early", {31'd0, instr_valid}, 32'd0);
      else begin
        chk("seq_pc",    instr_pc, 32'(4 * (i - 2)));
        chk("seq_instr", instr,    32'(4 * (i - 2)));
      end
      step(1'b1, 1'b0, '0);
    end

    // Back-pressure: exactly DEPTH acks, then one pop reopens at address 16.
    apply_reset();
    acks_seen = 0;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0);
    chk("full_acks", acks_seen, DEPTH);
    chk("full_req",  {31'd0, imem_req}, 32'd0);
    step(1'b1, 1'b0, '0);
    chk("reopen_req",  {31'd0, imem_req}, 32'd1);
    chk("reopen_addr", imem_addr, 32'd16);

    // Slow memory, redirect while fetch of 8 is pending.
    apply_reset();
    lat = 3;
    n = 0;
    while (!(imem_req && imem_addr == 32'd8) && n < 40) begin step(1'b1, 1'b0, '0); n++; end
    chk("wait_addr8", {31'd0, n < 40}, 32'd1);
    step(1'b1, 1'b1, 32'h100);
    chk("drain_req",  {31'd0, imem_req}, 32'd1);
    chk("drain_addr", imem_addr, 32'd8);
    n = 0;
    while (imem_addr == 32'd8 && n < 20) begin step(1'b1, 1'b0, '0); n++; end
    chk("drain_done", {31'd0, n < 20}, 32'd1);
    chk("post_drain_addr", imem_addr, 32'h100);
    n = 0;
    while (!instr_valid && n < 20) begin step(1'b1, 1'b0, '0); n++; end
    chk("post_drain_pc", instr_pc, 32'h100);

    // Redirect coinciding with ack and pop.
    lat = 0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
    chk("pre_same_valid", {31'd0, instr_valid && imem_req}, 32'd1);
    step(1'b1, 1'b1, 32'h200);
    chk("same_valid", {31'd0, instr_valid}, 32'd0);
    chk("same_req",   {31'd0, imem_req},    32'd1);
    chk("same_addr",  imem_addr,            32'h200);

    // Unaligned target and 32-bit wrap.
    step(1'b1, 1'b1, 32'h0000_0103);
    chk("align_addr", imem_addr, 32'h0000_0100);
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);

    // Randomized traffic.
    data_is_addr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      if (i % 200 == 0) lat = $urandom_range(0, 3);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, rpc);
    end

    // Reset in the middle of a drain.
    lat = 20;
    n = 0;
    while (!imem_req && n < 20) begin step(1'b1, 1'b0, '0); n++; end
    step(1'b1, 1'b1, 32'h400);
    chk("middrain_req", {31'd0, imem_req}, 32'd1);
    apply_reset();
    lat = 0; data_is_addr = 1'b1;
    step(1'b1, 1'b0, '0);
    chk("restart_req",  {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, RST_PC);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
